// File: rtl/group_commit_fifo.sv
// Multi-lane group-committed FIFO: rows become readable only once their group commits.
// Read latency: one cycle from commit edge to rd_valid via a single output register.
module group_commit_fifo #(
  parameter int DATA_W       = 16,
  parameter int LANES        = 4,
  parameter int GROUP_ROWS   = 4,
  parameter int DEPTH_GROUPS = 2,
  parameter int TAG_W        = 4
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               flush,
  input  logic                               wr_valid,
  output logic                               wr_ready,
  input  logic [LANES*DATA_W-1:0]            wr_data,
  input  logic                               wr_last,
  input  logic [TAG_W-1:0]                   wr_tag,
  input  logic                               wr_abort,
  output logic                               rd_valid,
  input  logic                               rd_ready,
  output logic [LANES*DATA_W-1:0]            rd_data,
  output logic                               rd_last,
  output logic [TAG_W-1:0]                   rd_tag,
  output logic [$clog2(DEPTH_GROUPS+1)-1:0]  groups_avail,
  output logic [$clog2(DEPTH_GROUPS+1)-1:0]  credit_out,
  output logic                               err_len,
  input  logic                               err_clr
);

  localparam int ROW_W = LANES * DATA_W;
  localparam int CW    = $clog2(DEPTH_GROUPS + 1);
  localparam int PW    = $clog2(DEPTH_GROUPS);
  localparam int RW    = $clog2(GROUP_ROWS);

  typedef enum logic [1:0] {S_FREE, S_OPEN, S_COMMITTED, S_READING} slot_state_t;

  slot_state_t       state     [DEPTH_GROUPS];
  slot_state_t       state_nxt [DEPTH_GROUPS];
  logic [ROW_W-1:0]  mem       [DEPTH_GROUPS][GROUP_ROWS];
  logic [TAG_W-1:0]  tag_mem   [DEPTH_GROUPS];
  logic [RW-1:0]     last_idx  [DEPTH_GROUPS];

  logic [PW-1:0] wr_ptr, wr_ptr_nxt, rd_ptr, rd_ptr_nxt, out_slot;
  logic [RW-1:0] wcnt, wcnt_nxt, rcnt, rcnt_nxt;
  logic          wr_fire, abort_hit, wr_commit, wr_store, err_set, load, pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH_GROUPS - 1)) ? '0 : p + 1'b1;
  endfunction

  assign wr_ready  = (state[wr_ptr] == S_FREE) || (state[wr_ptr] == S_OPEN);
  assign wr_fire   = wr_valid && wr_ready;
  assign abort_hit = wr_abort && (state[wr_ptr] == S_OPEN);
  assign wr_store  = wr_fire && !abort_hit && !flush;
  assign wr_commit = wr_last || (wcnt == RW'(GROUP_ROWS - 1));
  assign err_set   = wr_store && !wr_last && (wcnt == RW'(GROUP_ROWS - 1));
  assign pop       = rd_valid && rd_ready;
  assign load      = (!rd_valid || rd_ready) &&
                     ((state[rd_ptr] == S_COMMITTED) || (state[rd_ptr] == S_READING));

  // Abort beats a same-cycle row; the slot freed by a last-row pop is never the write or load slot.
  always_comb begin
    state_nxt  = state;
    wr_ptr_nxt = wr_ptr;
    wcnt_nxt   = wcnt;
    rd_ptr_nxt = rd_ptr;
    rcnt_nxt   = rcnt;
    if (abort_hit) begin
      state_nxt[wr_ptr] = S_FREE;
      wcnt_nxt          = '0;
    end else if (wr_fire) begin
      if (wr_commit) begin
        state_nxt[wr_ptr] = S_COMMITTED;
        wcnt_nxt          = '0;
        wr_ptr_nxt        = ptr_inc(wr_ptr);
      end else begin
        state_nxt[wr_ptr] = S_OPEN;
        wcnt_nxt          = wcnt + 1'b1;
      end
    end
    if (load) begin
      state_nxt[rd_ptr] = S_READING;
      if (rcnt == last_idx[rd_ptr]) begin
        rcnt_nxt   = '0;
        rd_ptr_nxt = ptr_inc(rd_ptr);
      end else begin
        rcnt_nxt = rcnt + 1'b1;
      end
    end
    if (pop && rd_last) state_nxt[out_slot] = S_FREE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH_GROUPS; i++) state[i] <= S_FREE;
      wr_ptr <= '0;
      wcnt   <= '0;
      rd_ptr <= '0;
      rcnt   <= '0;
    end else if (flush) begin
      for (int i = 0; i < DEPTH_GROUPS; i++) state[i] <= S_FREE;
      wr_ptr <= '0;
      wcnt   <= '0;
      rd_ptr <= '0;
      rcnt   <= '0;
    end else begin
      state  <= state_nxt;
      wr_ptr <= wr_ptr_nxt;
      wcnt   <= wcnt_nxt;
      rd_ptr <= rd_ptr_nxt;
      rcnt   <= rcnt_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_store) begin
      mem[wr_ptr][wcnt] <= wr_data;
      if (wcnt == '0) tag_mem[wr_ptr] <= wr_tag;
      if (wr_commit) last_idx[wr_ptr] <= wcnt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
      rd_last  <= 1'b0;
      rd_tag   <= '0;
      out_slot <= '0;
    end else if (flush) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
      rd_last  <= 1'b0;
      rd_tag   <= '0;
      out_slot <= '0;
    end else if (load) begin
      rd_valid <= 1'b1;
      rd_data  <= mem[rd_ptr][rcnt];
      rd_last  <= (rcnt == last_idx[rd_ptr]);
      rd_tag   <= tag_mem[rd_ptr];
      out_slot <= rd_ptr;
    end else if (pop) begin
      rd_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       err_len <= 1'b0;
    else if (err_set) err_len <= 1'b1;
    else if (err_clr) err_len <= 1'b0;
  end

  always_comb begin
    groups_avail = '0;
    credit_out   = '0;
    for (int i = 0; i < DEPTH_GROUPS; i++) begin
      if ((state[i] == S_COMMITTED) || (state[i] == S_READING)) groups_avail = groups_avail + CW'(1);
      if (state[i] == S_FREE) credit_out = credit_out + CW'(1);
    end
  end

endmodule

// File: tb/tb_group_commit_fifo.sv
// Bench for group_commit_fifo: directed scenarios then random traffic against a queue-based model.
module tb_group_commit_fifo;
  localparam int DEPTH = 2;
  localparam int GR    = 4;

  logic        clk = 1'b0;
  logic        rst_n, flush, wr_valid, wr_ready, wr_last, wr_abort;
  logic        rd_valid, rd_ready, rd_last, err_len, err_clr;
  logic [63:0] wr_data, rd_data;
  logic [3:0]  wr_tag, rd_tag;
  logic [1:0]  groups_avail, credit_out;

  int checks = 0;
  int errors = 0;
  int pop_cnt = 0;

  typedef struct packed {
    logic [63:0] d;
    logic        last;
    logic [3:0]  tag;
  } ent_t;

  ent_t        pending[$];
  logic [63:0] open_rows[$];
  ent_t        m_out;
  logic        m_out_valid, m_open, m_err;
  logic [3:0]  m_tag;
  int          m_held;

  group_commit_fifo dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data), .wr_last(wr_last),
    .wr_tag(wr_tag), .wr_abort(wr_abort),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last), .rd_tag(rd_tag),
    .groups_avail(groups_avail), .credit_out(credit_out),
    .err_len(err_len), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset(input logic clr_err);
    pending.delete();
    open_rows.delete();
    m_out       = '0;
    m_out_valid = 1'b0;
    m_open      = 1'b0;
    m_held      = 0;
    m_tag       = '0;
    if (clr_err) m_err = 1'b0;
  endtask

  // Transaction-level view: committed rows queue up in order, a group holds a slot until its last row leaves.
  task automatic model_step();
    ent_t e;
    logic can_wr, pop, pop_last;
    if (!rst_n) begin model_reset(1'b1); return; end
    if (err_clr) m_err = 1'b0;
    if (flush) begin model_reset(1'b0); return; end
    can_wr   = m_open || (m_held < DEPTH);
    pop      = m_out_valid && rd_ready;
    pop_last = pop && m_out.last;
    if ((!m_out_valid || rd_ready) && pending.size() > 0) begin
      m_out       = pending.pop_front();
      m_out_valid = 1'b1;
    end else if (pop) begin
      m_out_valid = 1'b0;
    end
    if (wr_abort && m_open) begin
      open_rows.delete();
      m_open = 1'b0;
    end else if (wr_valid && can_wr) begin
      if (!m_open) begin m_open = 1'b1; m_tag = wr_tag; end
      open_rows.push_back(wr_data);
      if (wr_last || open_rows.size() == GR) begin
        if (!wr_last) m_err = 1'b1;
        foreach (open_rows[i]) begin
          e.d    = open_rows[i];
          e.last = (i == open_rows.size() - 1);
          e.tag  = m_tag;
          pending.push_back(e);
        end
        open_rows.delete();
        m_open = 1'b0;
        m_held++;
      end
    end
    if (pop_last) m_held--;
  endtask

  task automatic check_all();
    chk("rd_valid", rd_valid, m_out_valid);
    chk("rd_data", rd_data, m_out.d);
    chk("rd_last", rd_last, m_out.last);
    chk("rd_tag", rd_tag, m_out.tag);
    chk("wr_ready", wr_ready, m_open || (m_held < DEPTH));
    chk("groups_avail", groups_avail, m_held);
    chk("credit_out", credit_out, DEPTH - m_held - int'(m_open));
    chk("err_len", err_len, m_err);
    chk("invariant", credit_out + groups_avail + m_open, DEPTH);
  endtask

  task automatic tick();
    if (rd_valid && rd_ready) pop_cnt++;
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic push_row(input logic [63:0] d, input logic last, input logic [3:0] tg);
    int n = 0;
    wr_valid = 1'b1; wr_data = d; wr_last = last; wr_tag = tg;
    while (!wr_ready && n < 50) begin tick(); n++; end
    chk("push_wr_ready", wr_ready, 1'b1);
    tick();
    wr_valid = 1'b0; wr_last = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; wr_valid = 1'b0; wr_last = 1'b0; wr_abort = 1'b0;
    rd_ready = 1'b0; err_clr = 1'b0; wr_data = '0; wr_tag = '0;
    model_reset(1'b1);
    #3;
    chk("rst_rd_valid", rd_valid, 1'b0);
    chk("rst_rd_data", rd_data, 64'h0);
    chk("rst_credit", credit_out, 2'd2);
    chk("rst_avail", groups_avail, 2'd0);
    chk("rst_wr_ready", wr_ready, 1'b1);
    chk("rst_err", err_len, 1'b0);
    tick();
    rst_n = 1'b1;
    tick();

    // 1: single 4-row group, tag 5
    rd_ready = 1'b1;
    for (int i = 0; i < 4; i++) push_row(64'hA000 + 64'(i), i == 3, 4'd5);
    chk("t1_latency", rd_valid, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t1_data", rd_data, 64'hA000 + 64'(i));
      chk("t1_last", rd_last, i == 3);
      chk("t1_tag", rd_tag, 4'd5);
    end
    tick();
    chk("t1_credit", credit_out, 2'd2);

    // 2: fill both slots without reading
    rd_ready = 1'b0;
    for (int i = 0; i < 8; i++) push_row(64'hB000 + 64'(i), (i % 4) == 3, 4'd1 + 4'(i / 4));
    chk("t2_wr_ready", wr_ready, 1'b0);
    chk("t2_credit", credit_out, 2'd0);
    chk("t2_avail", groups_avail, 2'd2);
    rd_ready = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    chk("t2_still_full", wr_ready, 1'b0);
    tick();
    chk("t2_freed", wr_ready, 1'b1);
    for (int i = 0; i < 5; i++) tick();

    // 3: abort, then a clean 3-row group, then abort coincident with wr_last
    push_row(64'hC000, 1'b0, 4'd3);
    push_row(64'hC001, 1'b0, 4'd3);
    wr_abort = 1'b1;
    tick();
    wr_abort = 1'b0;
    chk("t3_abort_credit", credit_out, 2'd2);
    for (int i = 0; i < 3; i++) push_row(64'hD000 + 64'(i), i == 2, 4'd9);
    tick();
    chk("t3_tag", rd_tag, 4'd9);
    chk("t3_first", rd_data, 64'hD000);
    for (int i = 0; i < 4; i++) tick();
    push_row(64'hE000, 1'b0, 4'd7);
    wr_valid = 1'b1; wr_last = 1'b1; wr_abort = 1'b1; wr_data = 64'hE001;
    tick();
    wr_valid = 1'b0; wr_last = 1'b0; wr_abort = 1'b0;
    tick();
    chk("t3_coincident_avail", groups_avail, 2'd0);
    chk("t3_coincident_valid", rd_valid, 1'b0);

    // 4: forced commit on overlong group
    rd_ready = 1'b0;
    for (int i = 0; i < 4; i++) push_row(64'hF000 + 64'(i), 1'b0, 4'd2);
    chk("t4_err", err_len, 1'b1);
    chk("t4_avail", groups_avail, 2'd1);
    rd_ready = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    chk("t4_last", rd_last, 1'b1);
    chk("t4_data", rd_data, 64'hF003);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("t4_clr", err_len, 1'b0);

    // 5: 20 back-to-back single-row groups
    tick();
    pop_cnt = 0;
    for (int i = 0; i < 20; i++) push_row(64'h1_0000 + 64'(i), 1'b1, 4'(i));
    for (int i = 0; i < 10; i++) tick();
    chk("t5_rows", pop_cnt, 20);

    // 6: reset mid-read, flush mid-write
    for (int i = 0; i < 4; i++) push_row(64'h2000 + 64'(i), i == 3, 4'd4);
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    model_reset(1'b1);
    #1;
    chk("t6_rst_valid", rd_valid, 1'b0);
    chk("t6_rst_credit", credit_out, 2'd2);
    check_all();
    tick();
    rst_n = 1'b1;
    tick();
    push_row(64'h3000, 1'b0, 4'd8);
    push_row(64'h3001, 1'b0, 4'd8);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("t6_flush_credit", credit_out, 2'd2);
    chk("t6_flush_ready", wr_ready, 1'b1);
    for (int i = 0; i < 3; i++) push_row(64'h4000 + 64'(i), i == 2, 4'd6);
    tick();
    chk("t6_tag", rd_tag, 4'd6);
    chk("t6_data", rd_data, 64'h4000);
    for (int i = 0; i < 4; i++) tick();

    // random traffic
    for (int c = 0; c < 400; c++) begin
      wr_valid = $urandom_range(0, 1) == 1;
      wr_last  = $urandom_range(0, 2) == 0;
      wr_abort = $urandom_range(0, 15) == 0;
      rd_ready = $urandom_range(0, 3) != 0;
      flush    = $urandom_range(0, 99) == 0;
      err_clr  = $urandom_range(0, 31) == 0;
      wr_data  = {$urandom, $urandom};
      wr_tag   = 4'($urandom_range(0, 15));
      tick();
    end
    wr_valid = 1'b0; wr_abort = 1'b0; flush = 1'b0; err_clr = 1'b0; rd_ready = 1'b1;
    for (int i = 0; i < 12; i++) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
